// File: rtl/text_pixel_render.sv
// Final text-path stage: pairs delayed glyph controls with the font-ROM row and drives registered RGB/syncs.
// Optional TEXT_BLINK_EN macro adds a vsync-driven blink counter that blanks lit glyph pixels.
`timescale 1ns/1ps

module text_pixel_render #(
    parameter int ROM_LATENCY  = 1,
    parameter int COLOR_W      = 4,
    parameter int BLINK_FRAMES = 30
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable_in,
    input  logic [2:0]           offset_x_in,
    input  logic [7:0]           rom_data,
    input  logic                 hsync_in,
    input  logic                 vsync_in,
    input  logic                 video_on_in,
    input  logic [3*COLOR_W-1:0] fg_color,
    input  logic [3*COLOR_W-1:0] bg_color,
    input  logic                 blink_req,
    output logic [3*COLOR_W-1:0] rgb_out,
    output logic                 hsync_out,
    output logic                 vsync_out,
    output logic                 video_on_out,
    output logic                 pixel_on
);

    localparam int Depth = (ROM_LATENCY < 1) ? 1 : ROM_LATENCY;

    generate
        if (ROM_LATENCY < 1 || ROM_LATENCY > 2) begin : g_bad_rom_latency
            $error("text_pixel_render: ROM_LATENCY must be 1 or 2");
        end
    endgenerate

    logic [Depth-1:0] enPipe_q;
    logic [Depth-1:0] hsPipe_q;
    logic [Depth-1:0] vsPipe_q;
    logic [Depth-1:0] vonPipe_q;
    logic [2:0]       offPipe_q [Depth];

    logic                 blankPhase;
    logic                 romBit;
    logic                 lit;
    logic [3*COLOR_W-1:0] rgb_d, rgb_q;
    logic                 pixOn_d, pixOn_q;
    logic                 hs_q, vs_q, von_q;

    // Control pipeline matching the ROM read latency; syncs idle high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            enPipe_q  <= '0;
            hsPipe_q  <= '1;
            vsPipe_q  <= '1;
            vonPipe_q <= '0;
            for (int i = 0; i < Depth; i++) offPipe_q[i] <= 3'd0;
        end else begin
            enPipe_q[0]  <= enable_in;
            hsPipe_q[0]  <= hsync_in;
            vsPipe_q[0]  <= vsync_in;
            vonPipe_q[0] <= video_on_in;
            offPipe_q[0] <= offset_x_in;
            for (int i = 1; i < Depth; i++) begin
                enPipe_q[i]  <= enPipe_q[i-1];
                hsPipe_q[i]  <= hsPipe_q[i-1];
                vsPipe_q[i]  <= vsPipe_q[i-1];
                vonPipe_q[i] <= vonPipe_q[i-1];
                offPipe_q[i] <= offPipe_q[i-1];
            end
        end
    end

`ifdef TEXT_BLINK_EN
    localparam int FrameW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [FrameW-1:0] frame_q, frame_d;
    logic              blinkPhase_q, blinkPhase_d;
    logic              vsyncPrev_q;
    logic              vsyncFall;

    always_comb begin
        frame_d      = frame_q;
        blinkPhase_d = blinkPhase_q;
        vsyncFall    = vsyncPrev_q & ~vsync_in;
        if (vsyncFall) begin
            if (frame_q == FrameW'(BLINK_FRAMES - 1)) begin
                frame_d      = '0;
                blinkPhase_d = ~blinkPhase_q;
            end else begin
                frame_d = frame_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_q      <= '0;
            blinkPhase_q <= 1'b0;
            vsyncPrev_q  <= 1'b1;
        end else begin
            frame_q      <= frame_d;
            blinkPhase_q <= blinkPhase_d;
            vsyncPrev_q  <= vsync_in;
        end
    end

    assign blankPhase = blink_req & blinkPhase_q;
`else
    localparam int unusedBlinkFrames = BLINK_FRAMES;
    logic unusedBlinkReq;
    assign unusedBlinkReq = blink_req;
    assign blankPhase     = 1'b0;
`endif

    // The ROM bit only matters when the cell is enabled, so an X row cannot leak into rgb.
    always_comb begin
        romBit = rom_data[3'd7 - offPipe_q[Depth-1]];
        lit    = 1'b0;
        if (enPipe_q[Depth-1]) lit = romBit & ~blankPhase;
        rgb_d = '0;
        if (vonPipe_q[Depth-1]) rgb_d = lit ? fg_color : bg_color;
        pixOn_d = vonPipe_q[Depth-1] & lit;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rgb_q   <= '0;
            pixOn_q <= 1'b0;
            hs_q    <= 1'b1;
            vs_q    <= 1'b1;
            von_q   <= 1'b0;
        end else begin
            rgb_q   <= rgb_d;
            pixOn_q <= pixOn_d;
            hs_q    <= hsPipe_q[Depth-1];
            vs_q    <= vsPipe_q[Depth-1];
            von_q   <= vonPipe_q[Depth-1];
        end
    end

    assign rgb_out      = rgb_q;
    assign pixel_on     = pixOn_q;
    assign hsync_out    = hs_q;
    assign vsync_out    = vs_q;
    assign video_on_out = von_q;

endmodule

// File: tb/tb_text_pixel_render.sv
// Directed bench for text_pixel_render: one ROM_LATENCY=1 instance and one ROM_LATENCY=2 instance share stimulus.
// Expected per-pixel values are hand-written at each applyStimulus call and checked at both latencies.
`timescale 1ns/1ps

module tb_text_pixel_render;

    logic        clk;
    logic        rst_n;
    logic        enable_in;
    logic [2:0]  offset_x_in;
    logic [7:0]  rom_data;
    logic [7:0]  rom_data2;
    logic        hsync_in;
    logic        vsync_in;
    logic        video_on_in;
    logic [11:0] fg_color;
    logic [11:0] bg_color;
    logic        blink_req;

    logic [11:0] rgb1, rgb2;
    logic        hs1, hs2, vs1, vs2, von1, von2, pix1, pix2;

    int checks   = 0;
    int failures = 0;

    logic [11:0] hRgb [256];
    logic        hPix [256];
    logic        hHs  [256];
    logic        hVs  [256];
    logic        hVon [256];
    int          nIdx;
    logic [7:0]  prevRow;
    logic        blankExp;

    text_pixel_render #(.ROM_LATENCY(1), .COLOR_W(4), .BLINK_FRAMES(2)) dut1 (
        .clk(clk), .rst_n(rst_n), .enable_in(enable_in), .offset_x_in(offset_x_in),
        .rom_data(rom_data), .hsync_in(hsync_in), .vsync_in(vsync_in),
        .video_on_in(video_on_in), .fg_color(fg_color), .bg_color(bg_color),
        .blink_req(blink_req), .rgb_out(rgb1), .hsync_out(hs1), .vsync_out(vs1),
        .video_on_out(von1), .pixel_on(pix1)
    );

    text_pixel_render #(.ROM_LATENCY(2), .COLOR_W(4), .BLINK_FRAMES(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .enable_in(enable_in), .offset_x_in(offset_x_in),
        .rom_data(rom_data2), .hsync_in(hsync_in), .vsync_in(vsync_in),
        .video_on_in(video_on_in), .fg_color(fg_color), .bg_color(bg_color),
        .blink_req(blink_req), .rgb_out(rgb2), .hsync_out(hs2), .vsync_out(vs2),
        .video_on_out(von2), .pixel_on(pix2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // The two-cycle ROM sees its row one cycle later than the one-cycle ROM.
    always @(posedge clk) rom_data2 <= rom_data;

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Slots 0 and 1 hold the idle values the pipelines carry out of reset.
    task automatic resetHistory();
        for (int i = 0; i < 2; i++) begin
            hRgb[i] = 12'h000; hPix[i] = 1'b0; hHs[i] = 1'b1; hVs[i] = 1'b1; hVon[i] = 1'b0;
        end
        nIdx    = 2;
        prevRow = 8'hxx;
    endtask

    task automatic checkOutput();
        int i1;
        int i2;
        i1 = nIdx - 2;
        i2 = nIdx - 3;
        checkVal($sformatf("lat1.rgb[%0d]", i1), 32'(rgb1), 32'(hRgb[i1]));
        checkVal($sformatf("lat1.pix[%0d]", i1), 32'(pix1), 32'(hPix[i1]));
        checkVal($sformatf("lat1.hs[%0d]", i1),  32'(hs1),  32'(hHs[i1]));
        checkVal($sformatf("lat1.vs[%0d]", i1),  32'(vs1),  32'(hVs[i1]));
        checkVal($sformatf("lat1.von[%0d]", i1), 32'(von1), 32'(hVon[i1]));
        checkVal($sformatf("lat2.rgb[%0d]", i2), 32'(rgb2), 32'(hRgb[i2]));
        checkVal($sformatf("lat2.pix[%0d]", i2), 32'(pix2), 32'(hPix[i2]));
        checkVal($sformatf("lat2.hs[%0d]", i2),  32'(hs2),  32'(hHs[i2]));
        checkVal($sformatf("lat2.vs[%0d]", i2),  32'(vs2),  32'(hVs[i2]));
        checkVal($sformatf("lat2.von[%0d]", i2), 32'(von2), 32'(hVon[i2]));
    endtask

    // One pixel per call; its font row is driven on the following call.
    task automatic applyStimulus(input logic en, input logic [2:0] off, input logic von,
                                 input logic hs, input logic vs, input logic [7:0] row,
                                 input logic [11:0] expRgb, input logic expPix);
        enable_in   = en;
        offset_x_in = off;
        video_on_in = von;
        hsync_in    = hs;
        vsync_in    = vs;
        rom_data    = prevRow;
        prevRow     = row;
        hRgb[nIdx] = expRgb; hPix[nIdx] = expPix; hHs[nIdx] = hs; hVs[nIdx] = vs; hVon[nIdx] = von;
        nIdx++;
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    task automatic checkIdle(input string tag);
        checkVal({tag, ".rgb1"}, 32'(rgb1), 32'h000);
        checkVal({tag, ".pix1"}, 32'(pix1), 32'h0);
        checkVal({tag, ".hs1"},  32'(hs1),  32'h1);
        checkVal({tag, ".vs1"},  32'(vs1),  32'h1);
        checkVal({tag, ".von1"}, 32'(von1), 32'h0);
        checkVal({tag, ".rgb2"}, 32'(rgb2), 32'h000);
        checkVal({tag, ".hs2"},  32'(hs2),  32'h1);
        checkVal({tag, ".vs2"},  32'(vs2),  32'h1);
    endtask

    initial begin
        logic [11:0] hsPat;
        logic [11:0] vsPat;
        hsPat = 12'b1011_0011_1010;
        vsPat = 12'b1101_1101_1011;

        rst_n = 1'b0;
        enable_in = 1'b0; offset_x_in = 3'd0; rom_data = 8'h00;
        hsync_in = 1'b1; vsync_in = 1'b1; video_on_in = 1'b0;
        fg_color = 12'hF00; bg_color = 12'h00F; blink_req = 1'b0;
        resetHistory();
        repeat (3) @(posedge clk);
        #1;
        checkIdle("reset");
        rst_n = 1'b1;

        $display("[TB] latency and bit select");
        applyStimulus(1'b1, 3'd0, 1'b1, 1'b1, 1'b1, 8'h80, 12'hF00, 1'b1);
        for (int o = 0; o < 8; o++)
            applyStimulus(1'b1, 3'(o), 1'b1, 1'b1, 1'b1, 8'h20,
                          (o == 2) ? 12'hF00 : 12'h00F, (o == 2));

        $display("[TB] blanking");
        applyStimulus(1'b1, 3'd3, 1'b0, 1'b1, 1'b1, 8'hFF, 12'h000, 1'b0);
        applyStimulus(1'b0, 3'd5, 1'b1, 1'b1, 1'b1, 8'hxx, 12'h00F, 1'b0);
        applyStimulus(1'b0, 3'd0, 1'b0, 1'b1, 1'b1, 8'hxx, 12'h000, 1'b0);
        applyStimulus(1'b1, 3'd7, 1'b1, 1'b1, 1'b1, 8'h01, 12'hF00, 1'b1);
        applyStimulus(1'b1, 3'd7, 1'b1, 1'b1, 1'b1, 8'hFE, 12'h00F, 1'b0);

        $display("[TB] sync alignment");
        for (int i = 0; i < 12; i++)
            applyStimulus(1'b0, 3'd0, 1'b1, hsPat[i], vsPat[i], 8'hxx, 12'h00F, 1'b0);
        applyStimulus(1'b0, 3'd0, 1'b0, 1'b1, 1'b1, 8'hxx, 12'h000, 1'b0);
        applyStimulus(1'b0, 3'd0, 1'b0, 1'b1, 1'b1, 8'hxx, 12'h000, 1'b0);

        $display("[TB] reset mid-line");
        applyStimulus(1'b1, 3'd0, 1'b1, 1'b0, 1'b1, 8'h80, 12'hF00, 1'b1);
        applyStimulus(1'b1, 3'd0, 1'b1, 1'b0, 1'b1, 8'h80, 12'hF00, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        checkIdle("midreset");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        resetHistory();
        applyStimulus(1'b1, 3'd0, 1'b1, 1'b1, 1'b1, 8'h80, 12'hF00, 1'b1);
        applyStimulus(1'b1, 3'd1, 1'b1, 1'b1, 1'b1, 8'h80, 12'h00F, 1'b0);
        applyStimulus(1'b0, 3'd0, 1'b0, 1'b1, 1'b1, 8'hxx, 12'h000, 1'b0);
        applyStimulus(1'b0, 3'd0, 1'b0, 1'b1, 1'b1, 8'hxx, 12'h000, 1'b0);

        $display("[TB] blink over vsync pulses");
        blink_req = 1'b1;
        for (int f = 0; f < 5; f++) begin
`ifdef TEXT_BLINK_EN
            blankExp = (f == 2) || (f == 3);
`else
            blankExp = 1'b0;
`endif
            for (int p = 0; p < 2; p++)
                applyStimulus(1'b1, 3'd0, 1'b1, 1'b1, 1'b1, 8'h80,
                              blankExp ? 12'h00F : 12'hF00, !blankExp);
            if (f < 4) begin
                applyStimulus(1'b0, 3'd0, 1'b0, 1'b1, 1'b1, 8'hxx, 12'h000, 1'b0);
                applyStimulus(1'b0, 3'd0, 1'b0, 1'b1, 1'b1, 8'hxx, 12'h000, 1'b0);
                applyStimulus(1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 8'hxx, 12'h000, 1'b0);
                applyStimulus(1'b0, 3'd0, 1'b0, 1'b1, 1'b1, 8'hxx, 12'h000, 1'b0);
            end
        end
        applyStimulus(1'b0, 3'd0, 1'b0, 1'b1, 1'b1, 8'hxx, 12'h000, 1'b0);
        applyStimulus(1'b0, 3'd0, 1'b0, 1'b1, 1'b1, 8'hxx, 12'h000, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
